// File: rtl/memfifo_width_bridge.sv
// -----------------------------------------------------------------------------
// memfifo_width_bridge
//
// Width bridge between the EZ-USB word stream (USB_WIDTH) and the DRAM FIFO
// (FIFO_WIDTH), both sides clocked by ifclk.
//
//   Host->memory : RATIO = FIFO_WIDTH/USB_WIDTH USB words are packed into one
//                  FIFO word. A flush pulse pads and commits a partial word.
//   Memory->host : FWFT FIFO words are unpacked into USB words back-to-back,
//                  with the next FIFO word popped on the last slot handshake.
//
// Parameters
//   USB_WIDTH   USB-side word width
//   FIFO_WIDTH  FIFO-side word width (integer multiple, RATIO >= 2)
//   MSB_FIRST   0: USB word k at bits [k*USB_WIDTH +: USB_WIDTH]
//               1: USB word 0 in the top slot
//   PAD_VALUE   value written into unfilled slots on flush
//
// Ports
//   ifclk, reset          clock, synchronous active-high reset
//   usb_data_out/_valid   host->FPGA words, usb_out_ready back-pressure
//   flush                 pulse, commit a partial pack word
//   fifo_data_in/_wr_en   packed word and write strobe, fifo_wr_full stalls
//   fifo_data_out         FWFT head word, fifo_rd_empty, fifo_rd_en pop
//   usb_data_in/_valid    FPGA->host words, usb_in_ready handshake
//   pack_level            USB words held on the pack side (saturates at RATIO)
//   unpack_level          USB words still to deliver from the unpack register
//   stat_*                32-bit wrapping event counters
//
// Optional feature
//   MEMFIFO_WIDTH_BRIDGE_STATS_EN: when defined the stat_* counters are built,
//   otherwise the stat_* ports are tied to 0.
// -----------------------------------------------------------------------------
module memfifo_width_bridge #(
  parameter int                   USB_WIDTH  = 16,
  parameter int                   FIFO_WIDTH = 128,
  parameter bit                   MSB_FIRST  = 1'b0,
  parameter logic [USB_WIDTH-1:0] PAD_VALUE  = '0,
  localparam int                  RATIO      = FIFO_WIDTH / USB_WIDTH,
  localparam int                  CNT_W      = (RATIO > 1) ? $clog2(RATIO) : 1,
  localparam int                  LVL_W      = $clog2(RATIO) + 1
) (
  input  logic                  ifclk,
  input  logic                  reset,
  input  logic [USB_WIDTH-1:0]  usb_data_out,
  input  logic                  usb_out_valid,
  output logic                  usb_out_ready,
  input  logic                  flush,
  output logic [FIFO_WIDTH-1:0] fifo_data_in,
  output logic                  fifo_wr_en,
  input  logic                  fifo_wr_full,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_rd_empty,
  output logic                  fifo_rd_en,
  output logic [USB_WIDTH-1:0]  usb_data_in,
  output logic                  usb_in_valid,
  input  logic                  usb_in_ready,
  output logic [LVL_W-1:0]      pack_level,
  output logic [LVL_W-1:0]      unpack_level,
  output logic [31:0]           stat_wr_words,
  output logic [31:0]           stat_rd_words,
  output logic [31:0]           stat_flushes
);

  generate
    if ((FIFO_WIDTH % USB_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
      $error("memfifo_width_bridge: FIFO_WIDTH must be a multiple of USB_WIDTH with RATIO >= 2");
    end
  endgenerate

  // Bit offset of USB slot k inside a FIFO word.
  function automatic int slot_pos(input int k);
    return MSB_FIRST ? (RATIO - 1 - k) * USB_WIDTH : k * USB_WIDTH;
  endfunction

  // Word count clamped to one FIFO word's worth of USB words.
  function automatic logic [LVL_W-1:0] sat_level(input int words);
    if (words > RATIO) return LVL_W'(RATIO);
    return LVL_W'(words);
  endfunction

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATIO - 1);

  // ---------------------------------------------------------------------------
  // Pack path state
  // ---------------------------------------------------------------------------
  logic [USB_WIDTH-1:0]  slot_q [RATIO];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  flush_req_q, flush_req_d;
  logic [FIFO_WIDTH-1:0] wreg_q, wreg_d;
  logic [FIFO_WIDTH-1:0] full_word, flush_word;
  logic                  accept;
  logic                  wr_fire;

  // A pending flush blocks input so the partial word cannot grow under it.
  assign usb_out_ready = !reset && !flush_req_q && (!pend_q || !fifo_wr_full);
  assign accept        = usb_out_valid && usb_out_ready;
  assign wr_fire       = !reset && pend_q && !fifo_wr_full;
  assign fifo_wr_en    = wr_fire;
  assign fifo_data_in  = reset ? '0 : wreg_q;

  // full_word merges the incoming word into slot cnt so a completing accept
  // commits without an extra cycle; flush_word pads slots cnt..RATIO-1.
  always_comb begin
    full_word  = '0;
    flush_word = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k == int'(cnt_q)) full_word[slot_pos(k) +: USB_WIDTH] = usb_data_out;
      else                  full_word[slot_pos(k) +: USB_WIDTH] = slot_q[k];
      flush_word[slot_pos(k) +: USB_WIDTH] = (k < int'(cnt_q)) ? slot_q[k] : PAD_VALUE;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    wreg_d      = wreg_q;
    flush_req_d = flush_req_q | flush;
    // Write first, so a reload in the same cycle wins over the clear.
    if (wr_fire) pend_d = 1'b0;
    if (accept) begin
      if (cnt_q == LAST_SLOT) begin
        wreg_d      = full_word;
        pend_d      = 1'b1;
        cnt_d       = '0;
        // A flush arriving with the completing word has nothing left to pad.
        flush_req_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (flush_req_q && !pend_q) begin
      flush_req_d = 1'b0;
      if (cnt_q != '0) begin
        wreg_d = flush_word;
        pend_d = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge ifclk) begin
    if (reset) begin
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      flush_req_q <= 1'b0;
      wreg_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      flush_req_q <= flush_req_d;
      wreg_q      <= wreg_d;
    end
  end

  // Slot storage carries data only; cnt_q decides which slots are live.
  always_ff @(posedge ifclk) begin
    if (accept) slot_q[cnt_q] <= usb_data_out;
  end

  assign pack_level = reset ? '0 : sat_level(int'(cnt_q) + (pend_q ? RATIO : 0));

  // ---------------------------------------------------------------------------
  // Unpack path
  // ---------------------------------------------------------------------------
  typedef enum logic {ST_IDLE, ST_HOLD} unpack_state_t;

  unpack_state_t         state_q;
  logic [CNT_W-1:0]      idx_q;
  logic [FIFO_WIDTH-1:0] rreg_q;
  logic                  last_hs;
  logic                  rd_fire;

  // Popping on the last-slot handshake keeps usb_in_valid high across words.
  assign last_hs    = (state_q == ST_HOLD) && usb_in_ready && (idx_q == LAST_SLOT);
  assign rd_fire    = !reset && !fifo_rd_empty && ((state_q == ST_IDLE) || last_hs);
  assign fifo_rd_en = rd_fire;

  always_ff @(posedge ifclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rreg_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd_fire) begin
            rreg_q  <= fifo_data_out;
            idx_q   <= '0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (usb_in_ready) begin
            if (idx_q == LAST_SLOT) begin
              idx_q <= '0;
              if (rd_fire) rreg_q  <= fifo_data_out;
              else         state_q <= ST_IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign usb_in_valid = !reset && (state_q == ST_HOLD);
  assign usb_data_in  = reset ? '0 : rreg_q[slot_pos(int'(idx_q)) +: USB_WIDTH];
  assign unpack_level = (reset || state_q != ST_HOLD) ? '0 : sat_level(RATIO - int'(idx_q));

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef MEMFIFO_WIDTH_BRIDGE_STATS_EN
  logic [31:0] wr_words_q, rd_words_q, flushes_q;
  logic        flush_fire;

  // Mirrors the flush service condition in the pack next-state logic.
  assign flush_fire = !reset && flush_req_q && !pend_q && (cnt_q != '0);

  always_ff @(posedge ifclk) begin
    if (reset) begin
      wr_words_q <= '0;
      rd_words_q <= '0;
      flushes_q  <= '0;
    end else begin
      if (wr_fire)    wr_words_q <= wr_words_q + 32'd1;
      if (rd_fire)    rd_words_q <= rd_words_q + 32'd1;
      if (flush_fire) flushes_q  <= flushes_q + 32'd1;
    end
  end

  assign stat_wr_words = reset ? '0 : wr_words_q;
  assign stat_rd_words = reset ? '0 : rd_words_q;
  assign stat_flushes  = reset ? '0 : flushes_q;
`else
  assign stat_wr_words = '0;
  assign stat_rd_words = '0;
  assign stat_flushes  = '0;
`endif

endmodule

// File: tb/tb_memfifo_width_bridge.sv
module tb_memfifo_width_bridge;

`ifdef MEMFIFO_WIDTH_BRIDGE_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic         ifclk = 1'b0;
  logic         reset;
  logic [15:0]  usb_data_out;
  logic         usb_out_valid;
  logic         flush;
  logic         fifo_wr_full;
  logic         usb_in_ready;
  logic [127:0] fifo_data_out;
  logic         fifo_rd_empty;

  // LSB-first instance
  logic         usb_out_ready, fifo_wr_en, fifo_rd_en, usb_in_valid;
  logic [127:0] fifo_data_in;
  logic [15:0]  usb_data_in;
  logic [3:0]   pack_level, unpack_level;
  logic [31:0]  stat_wr_words, stat_rd_words, stat_flushes;
  // MSB-first instance, same stimulus
  logic         usb_out_ready_m, fifo_wr_en_m, fifo_rd_en_m, usb_in_valid_m;
  logic [127:0] fifo_data_in_m;
  logic [15:0]  usb_data_in_m;
  logic [3:0]   pack_level_m, unpack_level_m;
  logic [31:0]  stat_wr_words_m, stat_rd_words_m, stat_flushes_m;

  memfifo_width_bridge #(.USB_WIDTH(16), .FIFO_WIDTH(128), .MSB_FIRST(1'b0), .PAD_VALUE(16'hFFFF)) dut (
    .ifclk(ifclk), .reset(reset), .usb_data_out(usb_data_out), .usb_out_valid(usb_out_valid),
    .usb_out_ready(usb_out_ready), .flush(flush), .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_full(fifo_wr_full), .fifo_data_out(fifo_data_out), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_en(fifo_rd_en), .usb_data_in(usb_data_in), .usb_in_valid(usb_in_valid),
    .usb_in_ready(usb_in_ready), .pack_level(pack_level), .unpack_level(unpack_level),
    .stat_wr_words(stat_wr_words), .stat_rd_words(stat_rd_words), .stat_flushes(stat_flushes));

  memfifo_width_bridge #(.USB_WIDTH(16), .FIFO_WIDTH(128), .MSB_FIRST(1'b1), .PAD_VALUE(16'hFFFF)) dut_m (
    .ifclk(ifclk), .reset(reset), .usb_data_out(usb_data_out), .usb_out_valid(usb_out_valid),
    .usb_out_ready(usb_out_ready_m), .flush(flush), .fifo_data_in(fifo_data_in_m), .fifo_wr_en(fifo_wr_en_m),
    .fifo_wr_full(fifo_wr_full), .fifo_data_out(fifo_data_out), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_en(fifo_rd_en_m), .usb_data_in(usb_data_in_m), .usb_in_valid(usb_in_valid_m),
    .usb_in_ready(usb_in_ready), .pack_level(pack_level_m), .unpack_level(unpack_level_m),
    .stat_wr_words(stat_wr_words_m), .stat_rd_words(stat_rd_words_m), .stat_flushes(stat_flushes_m));

  always #5 ifclk = ~ifclk;

  // FWFT FIFO model: words preloaded by the stimulus, popped on fifo_rd_en.
  logic [127:0] pre_mem [16];
  int           pre_cnt = 0;
  int           rd_ptr  = 0;
  assign fifo_rd_empty = (rd_ptr >= pre_cnt);
  assign fifo_data_out = pre_mem[rd_ptr[3:0]];

  int cyc = 0;
  always @(posedge ifclk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && !fifo_rd_empty) rd_ptr <= rd_ptr + 1;
  end

  // Transaction log, sampled mid-cycle (what the next rising edge will do).
  logic [127:0] wr_log [$];
  logic [127:0] wr_log_m [$];
  int           wr_cyc [$];
  logic [15:0]  rx_log [$];
  logic [15:0]  rx_log_m [$];
  int           rx_cyc [$];
  int           acc_cyc_last = 0;
  int           pops = 0;

  always @(negedge ifclk) begin
    if (fifo_wr_en) begin
      wr_log.push_back(fifo_data_in);
      wr_log_m.push_back(fifo_data_in_m);
      wr_cyc.push_back(cyc);
    end
    if (usb_out_valid && usb_out_ready) acc_cyc_last <= cyc;
    if (fifo_rd_en) pops <= pops + 1;
    if (usb_in_valid && usb_in_ready) begin
      rx_log.push_back(usb_data_in);
      rx_log_m.push_back(usb_data_in_m);
      rx_cyc.push_back(cyc);
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected FIFO word from the USB words in arrival order, padding after n.
  function automatic logic [127:0] pack_exp(input logic [15:0] ws [16], input int base,
                                            input int n, input bit msb);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      logic [15:0] v;
      v = (k < n) ? ws[base + k] : 16'hFFFF;
      r = r | (128'(v) << (16 * (msb ? 7 - k : k)));
    end
    return r;
  endfunction

  task automatic next_drive();
    @(posedge ifclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ifclk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    logic a;
    int   guard;
    a = 1'b0;
    guard = 0;
    usb_data_out  = w;
    usb_out_valid = 1'b1;
    while (!a && guard < 200) begin
      @(negedge ifclk);
      a = usb_out_ready;
      @(posedge ifclk);
      #1;
      guard++;
    end
    if (!a) chk("send_timeout", 128'(a), 128'd1);
    usb_out_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  w [16];
    logic [127:0] fw [4];
    int n0, nrx, p0, idx, acc_full;
    logic         prev_stall;
    logic [15:0]  prev_data;

    reset = 1'b1; usb_data_out = '0; usb_out_valid = 1'b0; flush = 1'b0;
    fifo_wr_full = 1'b0; usb_in_ready = 1'b0;
    for (int i = 0; i < 16; i++) pre_mem[i] = '0;
    idle(3);
    @(negedge ifclk);
    chk("rst_ready",   128'(usb_out_ready), 128'd0);
    chk("rst_wr_en",   128'(fifo_wr_en), 128'd0);
    chk("rst_rd_en",   128'(fifo_rd_en), 128'd0);
    chk("rst_valid",   128'(usb_in_valid), 128'd0);
    chk("rst_levels",  128'({pack_level, unpack_level}), 128'd0);
    chk("rst_data",    fifo_data_in | 128'(usb_data_in), 128'd0);
    chk("rst_stats",   128'({stat_wr_words, stat_rd_words, stat_flushes}), 128'd0);
    next_drive();
    reset = 1'b0;
    idle(2);

    // Eight ascending words, back to back.
    n0 = wr_log.size();
    for (int k = 0; k < 8; k++) send(16'(k + 1));
    idle(3);
    chk("t1_nwr",  128'(wr_log.size() - n0), 128'd1);
    chk("t1_data", wr_log[n0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("t1_lat",  128'(wr_cyc[n0] - acc_cyc_last), 128'd1);
    chk("t2_msb",  wr_log_m[n0], 128'h0001_0002_0003_0004_0005_0006_0007_0008);

    // Partial word plus flush.
    n0 = wr_log.size();
    send(16'hAAAA); send(16'hBBBB); send(16'hCCCC);
    @(negedge ifclk);
    chk("t3_level", 128'(pack_level), 128'd3);
    next_drive();
    flush = 1'b1;
    next_drive();
    flush = 1'b0;
    idle(4);
    chk("t3_nwr",   128'(wr_log.size() - n0), 128'd1);
    chk("t3_data",  wr_log[n0], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_CCCC_BBBB_AAAA);
    chk("t3_msb",   wr_log_m[n0], 128'hAAAA_BBBB_CCCC_FFFF_FFFF_FFFF_FFFF_FFFF);
    chk("t3_stat",  128'(stat_flushes), 128'(STATS_ON ? 1 : 0));

    // Flush with nothing held.
    n0 = wr_log.size();
    flush = 1'b1;
    next_drive();
    flush = 1'b0;
    idle(4);
    chk("t3_empty_nwr", 128'(wr_log.size() - n0), 128'd0);
    @(negedge ifclk);
    chk("t3_empty_rdy", 128'(usb_out_ready), 128'd1);
    chk("t3_empty_stat", 128'(stat_flushes), 128'(STATS_ON ? 1 : 0));
    next_drive();

    // Flush arriving together with the word that completes a FIFO word.
    n0 = wr_log.size();
    for (int k = 0; k < 8; k++) w[k] = 16'($urandom);
    for (int k = 0; k < 7; k++) send(w[k]);
    flush = 1'b1;
    send(w[7]);
    flush = 1'b0;
    idle(5);
    chk("t3c_nwr",  128'(wr_log.size() - n0), 128'd1);
    chk("t3c_data", wr_log[n0], pack_exp(w, 0, 8, 1'b0));
    chk("t3c_stat", 128'(stat_flushes), 128'(STATS_ON ? 1 : 0));

    // Back-pressure: FIFO full for 20 cycles while 16 words are offered.
    n0 = wr_log.size();
    for (int k = 0; k < 16; k++) w[k] = 16'($urandom);
    idx = 0;
    acc_full = 0;
    for (int c = 0; c < 300 && !(idx == 16 && c >= 30); c++) begin
      logic a;
      fifo_wr_full  = (c < 20);
      usb_out_valid = (idx < 16);
      usb_data_out  = w[(idx < 16) ? idx : 0];
      @(negedge ifclk);
      a = usb_out_ready && usb_out_valid;
      if (c == 19) begin
        chk("t4_rdy_low", 128'(usb_out_ready), 128'd0);
        chk("t4_lvl",     128'(pack_level), 128'd8);
        chk("t4_no_wr",   128'(wr_log.size() - n0), 128'd0);
      end
      @(posedge ifclk);
      #1;
      if (a) begin
        idx++;
        if (c < 20) acc_full++;
      end
    end
    usb_out_valid = 1'b0;
    fifo_wr_full  = 1'b0;
    idle(3);
    chk("t4_acc_full", 128'(acc_full), 128'd8);
    chk("t4_acc_all",  128'(idx), 128'd16);
    chk("t4_nwr",      128'(wr_log.size() - n0), 128'd2);
    chk("t4_data0",    wr_log[n0],       pack_exp(w, 0, 8, 1'b0));
    chk("t4_data1",    wr_log[n0 + 1],   pack_exp(w, 8, 8, 1'b0));
    chk("t4_msb1",     wr_log_m[n0 + 1], pack_exp(w, 8, 8, 1'b1));

    // Unpack two FIFO words with the host always ready.
    for (int j = 0; j < 4; j++) fw[j] = {$urandom, $urandom, $urandom, $urandom};
    nrx = rx_log.size();
    p0  = pops;
    usb_in_ready = 1'b1;
    pre_mem[pre_cnt[3:0]]       = fw[0];
    pre_mem[4'(pre_cnt + 1)]    = fw[1];
    pre_cnt = pre_cnt + 2;
    idle(25);
    chk("t5_nrx",  128'(rx_log.size() - nrx), 128'd16);
    chk("t5_gap",  128'(rx_cyc[nrx + 15] - rx_cyc[nrx]), 128'd15);
    chk("t5_pops", 128'(pops - p0), 128'd2);
    for (int j = 0; j < 16; j++) begin
      chk("t5_word",     128'(rx_log[nrx + j]),   128'(fw[j / 8][16 * (j % 8) +: 16]));
      chk("t5_word_msb", 128'(rx_log_m[nrx + j]), 128'(fw[j / 8][16 * (7 - j % 8) +: 16]));
    end

    // Unpack again with the host ready toggling randomly.
    nrx = rx_log.size();
    p0  = pops;
    usb_in_ready = 1'b0;
    pre_mem[pre_cnt[3:0]]       = fw[2];
    pre_mem[4'(pre_cnt + 1)]    = fw[3];
    pre_cnt = pre_cnt + 2;
    idle(3);
    @(negedge ifclk);
    chk("t5r_valid", 128'(usb_in_valid), 128'd1);
    chk("t5r_level", 128'(unpack_level), 128'd8);
    chk("t5r_head",  128'(usb_data_in), 128'(fw[2][15:0]));
    chk("t5r_head_msb", 128'(usb_data_in_m), 128'(fw[2][127:112]));
    next_drive();
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 400 && (rx_log.size() - nrx) < 16; c++) begin
      usb_in_ready = 1'($urandom_range(0, 1));
      @(negedge ifclk);
      if (prev_stall) chk("t5r_stable", 128'(usb_data_in), 128'(prev_data));
      prev_stall = usb_in_valid && !usb_in_ready;
      prev_data  = usb_data_in;
      @(posedge ifclk);
      #1;
    end
    usb_in_ready = 1'b0;
    idle(2);
    chk("t5r_nrx",  128'(rx_log.size() - nrx), 128'd16);
    chk("t5r_pops", 128'(pops - p0), 128'd2);
    for (int j = 0; j < 16; j++)
      chk("t5r_word", 128'(rx_log[nrx + j]), 128'(fw[2 + j / 8][16 * (j % 8) +: 16]));
    @(negedge ifclk);
    chk("t5r_idle", 128'(unpack_level), 128'd0);
    chk("stat_wr",  128'(stat_wr_words), 128'(STATS_ON ? 5 : 0));
    chk("stat_rd",  128'(stat_rd_words), 128'(STATS_ON ? 4 : 0));
    next_drive();

    // Reset in the middle of a pack (cnt=5) and an unpack (idx=3).
    for (int k = 0; k < 5; k++) send(16'($urandom));
    @(negedge ifclk);
    chk("t6_pack_lvl", 128'(pack_level), 128'd5);
    next_drive();
    pre_mem[pre_cnt[3:0]] = {$urandom, $urandom, $urandom, $urandom};
    pre_cnt = pre_cnt + 1;
    idle(2);
    usb_in_ready = 1'b1;
    idle(3);
    usb_in_ready = 1'b0;
    @(negedge ifclk);
    chk("t6_unpack_lvl", 128'(unpack_level), 128'd5);
    nrx = rx_log.size();
    next_drive();
    reset = 1'b1;
    @(negedge ifclk);
    chk("t6_rst_ctl",  128'({usb_out_ready, fifo_wr_en, fifo_rd_en, usb_in_valid}), 128'd0);
    chk("t6_rst_lvl",  128'({pack_level, unpack_level}), 128'd0);
    chk("t6_rst_data", fifo_data_in | 128'(usb_data_in), 128'd0);
    next_drive();
    reset = 1'b0;
    @(negedge ifclk);
    chk("t6_post_lvl",   128'({pack_level, unpack_level}), 128'd0);
    chk("t6_post_valid", 128'(usb_in_valid), 128'd0);
    chk("t6_post_ready", 128'(usb_out_ready), 128'd1);
    chk("t6_post_stats", 128'({stat_wr_words, stat_rd_words, stat_flushes}), 128'd0);
    next_drive();
    n0 = wr_log.size();
    for (int k = 0; k < 8; k++) begin
      w[k] = 16'($urandom);
      send(w[k]);
    end
    idle(3);
    chk("t6_nwr",     128'(wr_log.size() - n0), 128'd1);
    chk("t6_data",    wr_log[n0],   pack_exp(w, 0, 8, 1'b0));
    chk("t6_msb",     wr_log_m[n0], pack_exp(w, 0, 8, 1'b1));
    chk("t6_dropped", 128'(rx_log.size() - nrx), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
